// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that funnels NREQ requester streams into a
// single downstream sync FIFO write port. Each grant carries at most MAX_BURST
// beats, every release of the grant costs one idle cycle, and writes are throttled
// so the FIFO never holds more than DEPTH entries.
// Register updates are zero-delay here; DLY is only accepted and range-checked so
// that integrations which set it still elaborate unchanged.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NREQ      = 4,
    parameter int DEPTH     = 16,
    parameter int ELS_SIZE  = $clog2(DEPTH),
    parameter int MAX_BURST = 4,
    parameter int DLY       = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*WIDTH-1:0]     req_data_i,
    output logic [NREQ-1:0]           req_ready_o,
    output logic                      fifo_wr_en_o,
    output logic [WIDTH-1:0]          fifo_wdata_o,
    input  logic [ELS_SIZE:0]         fifo_elements_i,
    output logic                      grant_vld_o,
    output logic [$clog2(NREQ)-1:0]   grant_id_o
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = 8;

    if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 || DLY < 0) begin : g_paramCheck
        $error("fifo_wr_arbiter: NREQ, MAX_BURST or DLY outside the supported range");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e              state_q;
    logic [IDW-1:0]      grantId_q;
    logic [IDW-1:0]      grantId_d;
    logic [IDW-1:0]      lastId_q;
    logic [CNTW-1:0]     beatCnt_q;
    logic                wrEn_q;
    logic [WIDTH-1:0]    wdata_q;

    logic [ELS_SIZE+1:0] occupancy;
    logic                spaceOk;
    logic                ownerValid;
    logic [WIDTH-1:0]    ownerData;
    logic                accept;
    logic                lastBeat;

    // Occupancy counts the write already in flight so a full FIFO is never overrun.
    assign occupancy  = {1'b0, fifo_elements_i} + {{(ELS_SIZE + 1){1'b0}}, wrEn_q};
    assign spaceOk    = occupancy < (ELS_SIZE + 2)'(DEPTH);
    assign ownerValid = req_valid_i[grantId_q];
    assign ownerData  = req_data_i[int'(grantId_q) * WIDTH +: WIDTH];
    assign accept     = (state_q == GRANT) && ownerValid && spaceOk;
    assign lastBeat   = beatCnt_q == CNTW'(MAX_BURST - 1);

    // Round-robin pick: the lowest offset above the previous owner wins, so scan downward.
    always_comb begin
        grantId_d = grantId_q;
        for (int i = NREQ; i >= 1; i--) begin
            if (req_valid_i[IDW'((int'(lastId_q) + i) % NREQ)]) begin
                grantId_d = IDW'((int'(lastId_q) + i) % NREQ);
            end
        end
    end

    // Only the owner sees ready, and only while the FIFO can take another entry.
    always_comb begin
        req_ready_o = '0;
        if (state_q == GRANT && spaceOk) begin
            req_ready_o[grantId_q] = 1'b1;
        end
    end

    // Grant state machine together with the registered FIFO write port.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            grantId_q <= '0;
            lastId_q  <= IDW'(NREQ - 1);
            beatCnt_q <= '0;
            wrEn_q    <= 1'b0;
            wdata_q   <= '0;
        end else begin
            wrEn_q <= accept;
            if (accept) begin
                wdata_q <= ownerData;
            end
            case (state_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        state_q   <= GRANT;
                        grantId_q <= grantId_d;
                        beatCnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (!ownerValid) begin
                        state_q  <= IDLE;
                        lastId_q <= grantId_q;
                    end else if (accept) begin
                        beatCnt_q <= beatCnt_q + CNTW'(1);
                        if (lastBeat) begin
                            state_q  <= IDLE;
                            lastId_q <= grantId_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_wr_en_o = wrEn_q;
    assign fifo_wdata_o = wdata_q;
    assign grant_vld_o  = (state_q == GRANT);
    assign grant_id_o   = grantId_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: drives preloaded requester streams into the arbiter, models the
// downstream FIFO occupancy, and compares the write stream and burst structure
// against a transaction-level round-robin prediction.
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 32;
    localparam int NREQ      = 4;
    localparam int DEPTH     = 16;
    localparam int ELS_SIZE  = $clog2(DEPTH);
    localparam int MAX_BURST = 4;
    localparam int IDW       = $clog2(NREQ);

    logic                  clk_i;
    logic                  rst_n_i;
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ*WIDTH-1:0] req_data_i;
    logic [NREQ-1:0]       req_ready_o;
    logic                  fifo_wr_en_o;
    logic [WIDTH-1:0]      fifo_wdata_o;
    logic [ELS_SIZE:0]     fifo_elements_i;
    logic                  grant_vld_o;
    logic [IDW-1:0]        grant_id_o;

    logic [WIDTH-1:0] srcQ [NREQ][$];
    logic [WIDTH-1:0] expQ [$];
    int               expBurstOwner [$];
    int               expBurstLen [$];
    int               beatNum [NREQ];
    int               lastOwner;
    int               fifoCount;
    int               drainPct;
    int               holdOff;
    int               vectors;
    int               miscompares;

    fifo_wr_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH), .ELS_SIZE(ELS_SIZE),
        .MAX_BURST(MAX_BURST), .DLY(1)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .fifo_wr_en_o(fifo_wr_en_o),
        .fifo_wdata_o(fifo_wdata_o),
        .fifo_elements_i(fifo_elements_i),
        .grant_vld_o(grant_vld_o),
        .grant_id_o(grant_id_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveInputs();
        for (int k = 0; k < NREQ; k++) begin
            if (srcQ[k].size() > 0) begin
                req_valid_i[k] = 1'b1;
                req_data_i[k*WIDTH +: WIDTH] = srcQ[k][0];
            end else begin
                req_valid_i[k] = 1'b0;
                req_data_i[k*WIDTH +: WIDTH] = '0;
            end
        end
        fifo_elements_i = (ELS_SIZE + 1)'(fifoCount);
    endtask

    // One clock: sample handshakes before the edge, apply their effects just after it.
    task automatic cycleStep();
        logic [NREQ-1:0] acc;
        logic            wr;
        @(negedge clk_i);
        acc = req_valid_i & req_ready_o;
        wr  = fifo_wr_en_o;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (acc[k] && srcQ[k].size() > 0) srcQ[k].delete(0);
        end
        fifoCount += int'(wr);
        if (holdOff > 0) holdOff--;
        else if (fifoCount > 0 && int'($urandom_range(99)) < drainPct) fifoCount--;
        driveInputs();
    endtask

    function automatic int pickNext(input int remaining[NREQ], input int after);
        int k;
        for (int i = 1; i <= NREQ; i++) begin
            k = (after + i) % NREQ;
            if (remaining[k] > 0) return k;
        end
        return 0;
    endfunction

    // Loads each requester's stream and predicts the full write order and burst list.
    task automatic loadRound(input int lens[NREQ]);
        int remaining[NREQ];
        int taken[NREQ];
        int owner;
        int n;
        int total;
        total = 0;
        for (int k = 0; k < NREQ; k++) begin
            remaining[k] = lens[k];
            taken[k] = 0;
            total += lens[k];
            for (int b = 0; b < lens[k]; b++) begin
                srcQ[k].push_back({16'($urandom), 8'(k), 8'(beatNum[k])});
                beatNum[k]++;
            end
        end
        while (total > 0) begin
            owner = pickNext(remaining, lastOwner);
            n = (remaining[owner] < MAX_BURST) ? remaining[owner] : MAX_BURST;
            for (int j = 0; j < n; j++) expQ.push_back(srcQ[owner][taken[owner] + j]);
            taken[owner] += n;
            remaining[owner] -= n;
            total -= n;
            expBurstOwner.push_back(owner);
            expBurstLen.push_back(n);
            lastOwner = owner;
        end
        driveInputs();
    endtask

    function automatic bit roundDone();
        for (int k = 0; k < NREQ; k++) if (srcQ[k].size() > 0) return 1'b0;
        return expQ.size() == 0 && expBurstOwner.size() == 0 && !fifo_wr_en_o;
    endfunction

    task automatic flushAll();
        for (int k = 0; k < NREQ; k++) srcQ[k].delete();
        expQ.delete();
        expBurstOwner.delete();
        expBurstLen.delete();
    endtask

    task automatic applyStimulus(input int lens[NREQ], input int hold);
        int budget;
        holdOff = hold;
        loadRound(lens);
        budget = 3000;
        while (!roundDone() && budget > 0) begin
            cycleStep();
            budget--;
        end
        if (!roundDone()) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL roundTimeout: %0d writes still outstanding, expected 0", expQ.size());
            flushAll();
            driveInputs();
        end
        cycleStep();
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstReady",    64'(req_ready_o),  64'd0);
        checkOutput("rstWrEn",     64'(fifo_wr_en_o), 64'd0);
        checkOutput("rstWdata",    64'(fifo_wdata_o), 64'd0);
        checkOutput("rstGrantVld", 64'(grant_vld_o),  64'd0);
        checkOutput("rstGrantId",  64'(grant_id_o),   64'd0);
    endtask

    // Monitor: pops the scoreboard on every FIFO write and checks burst/ready rules.
    initial begin
        logic [NREQ-1:0]  prevAcc;
        logic [NREQ-1:0]  curAcc;
        logic             prevGrant;
        logic             prevAnyValid;
        logic [IDW-1:0]   prevId;
        int               segBeats;
        logic [WIDTH-1:0] expData;
        prevAcc = '0; prevGrant = 1'b0; prevAnyValid = 1'b0; prevId = '0; segBeats = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                prevAcc = '0; prevGrant = 1'b0; prevAnyValid = 1'b0; prevId = '0; segBeats = 0;
            end else begin
                curAcc = req_valid_i & req_ready_o;
                checkOutput("wrLatency", 64'(fifo_wr_en_o), 64'(|prevAcc));
                if (fifo_wr_en_o) begin
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL extraWrite: got data 0x%0h, expected no write", fifo_wdata_o);
                    end else begin
                        expData = expQ.pop_front();
                        checkOutput("wdata", 64'(fifo_wdata_o), 64'(expData));
                    end
                end
                checkOutput("fifoBound", 64'(fifoCount + int'(fifo_wr_en_o) <= DEPTH), 64'd1);
                if (fifoCount + int'(fifo_wr_en_o) >= DEPTH) checkOutput("readyWhenFull", 64'(req_ready_o), 64'd0);
                checkOutput("readyShape", 64'(req_ready_o == '0 || (grant_vld_o && $onehot(req_ready_o))), 64'd1);
                if (!prevGrant && prevAnyValid) checkOutput("oneIdleCycle", 64'(grant_vld_o), 64'd1);
                if (prevGrant && grant_vld_o) checkOutput("grantIdStable", 64'(grant_id_o), 64'(prevId));
                if (prevGrant && !grant_vld_o) begin
                    if (expBurstOwner.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL extraBurst: got owner %0d with %0d beats, expected none", prevId, segBeats);
                    end else begin
                        checkOutput("burstOwner", 64'(prevId), 64'(expBurstOwner.pop_front()));
                        checkOutput("burstLen", 64'(segBeats), 64'(expBurstLen.pop_front()));
                    end
                end
                if (grant_vld_o) begin
                    if (!prevGrant) segBeats = 0;
                    segBeats += $countones(curAcc);
                end
                prevAcc = curAcc;
                prevGrant = grant_vld_o;
                prevAnyValid = |req_valid_i;
                prevId = grant_id_o;
            end
        end
    end

    // Directed scenarios first, then randomized rounds, then a mid-burst reset.
    initial begin
        int lens[NREQ];
        vectors = 0; miscompares = 0; fifoCount = 0; drainPct = 60; holdOff = 0;
        lastOwner = NREQ - 1;
        for (int k = 0; k < NREQ; k++) beatNum[k] = 0;
        rst_n_i = 1'b0;
        req_valid_i = '0;
        req_data_i = '0;
        fifo_elements_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        checkResetOutputs();
        #1 rst_n_i = 1'b1;

        $display("[TB] directed rounds");
        applyStimulus('{4, 4, 4, 4}, 0);
        applyStimulus('{0, 0, 10, 0}, 0);
        applyStimulus('{1, 0, 0, 0}, 0);
        applyStimulus('{0, 2, 0, 5}, 0);
        drainPct = 35;
        applyStimulus('{9, 9, 9, 9}, 60);

        $display("[TB] random rounds");
        for (int r = 0; r < 12; r++) begin
            drainPct = int'($urandom_range(20, 100));
            for (int k = 0; k < NREQ; k++) lens[k] = int'($urandom_range(0, 9));
            applyStimulus(lens, int'($urandom_range(0, 10)));
        end

        $display("[TB] reset during a burst");
        drainPct = 100;
        fifoCount = 0;
        driveInputs();
        loadRound('{0, 0, 10, 0});
        repeat (4) cycleStep();
        checkOutput("preRstGrantVld", 64'(grant_vld_o), 64'd1);
        checkOutput("preRstGrantId", 64'(grant_id_o), 64'd2);
        #2 rst_n_i = 1'b0;
        #1 checkResetOutputs();
        flushAll();
        lastOwner = NREQ - 1;
        driveInputs();
        repeat (2) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        drainPct = 50;
        applyStimulus('{3, 2, 4, 1}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
